apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
// PURPOSE
//  APB3 master controller: arbitrates NUM_REQ local requesters round-robin and sequences one APB3
//  transfer at a time (IDLE->SETUP->ACCESS) onto the shared slave bus. Sits between on-chip
//  requesters/VIP stimulus and the APB3 slave; drives psel/penable/paddr/pwrite/pwdata.
//  Returns rdata/error per transfer. Guards against a hung slave with a pready timeout.
// PARAMETERS
//  NUM_REQ         4   number of requesters (1..8)
//  AW              8   APB address width
//  DW              32  APB data width
//  TIMEOUT_CYCLES  16  max ACCESS cycles waiting for pready; 0 = timeout disabled
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst_n        in   1           reset; asynchronous and active-low
//  req_valid    in   NUM_REQ     request pending, held until req_accept
//  req_write    in   NUM_REQ     1=write 0=read, bit i per requester
//  req_addr     in   NUM_REQ*AW  address, slice i = [i*AW +: AW]
//  req_wdata    in   NUM_REQ*DW  write data, slice i = [i*DW +: DW]
//  req_accept   out  NUM_REQ     one-hot 1-cycle pulse: request latched (cycle of SETUP)
//  rsp_valid    out  1           1-cycle pulse: transfer complete
//  rsp_id       out  ID_W        requester index of completed transfer (ID_W=max(1,clog2(NUM_REQ)))
//  rsp_rdata    out  DW          read data (0 for writes and timeouts)
//  rsp_err      out  1           pslverr sampled high, or timeout
//  psel         out  1           APB select
//  penable      out  1           APB enable
//  pwrite       out  1           APB direction
//  paddr        out  AW          APB address
//  pwdata       out  DW          APB write data
//  prdata       in   DW          APB read data
//  pready       in   1           APB ready
//  pslverr      in   1           APB slave error
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, state IDLE, wait counter 0, rr pointer = NUM_REQ-1
//    (req 0 highest priority first). Transfer in flight is aborted; no rsp_valid generated.
//  - All outputs registered. Arbitration: first valid index after last granted, wrapping.
//  - IDLE: psel=0 penable=0. If any req_valid at edge N: latch winner -> SETUP; at N+1 psel=1,
//    penable=0, paddr/pwrite/pwdata from winner, req_accept[winner]=1 for that cycle only.
//  - SETUP: exactly one cycle -> ACCESS (penable=1, psel=1). paddr/pwrite/pwdata stable.
//  - ACCESS: counter increments each cycle pready=0. On pready=1 edge: rsp_valid=1 next cycle
//    with rsp_id, rsp_err=pslverr, rsp_rdata=pwrite?0:prdata; penable=0. If another req_valid
//    (excluding just-served requester unless sole) go SETUP directly (psel stays 1), else IDLE.
//  - Timeout: counter reaching TIMEOUT_CYCLES with pready=0 ends transfer as above with
//    rsp_err=1, rsp_rdata=0; psel/penable drop to 0 next cycle; always returns via IDLE.
//  - Counter saturates; width clog2(TIMEOUT_CYCLES+1). Counter cleared on each SETUP.
//  - Idle bus: paddr/pwrite/pwdata hold last values. prdata/pslverr ignored outside ACCESS&pready.
//  - req_valid dropped before accept: not an error; arbiter simply skips it.
//  - Minimum transfer: 2 cycles (SETUP+ACCESS); rsp latency from accept = 2 + wait states.
// STRUCTURE
//  - apb_ctrl_pkg: state enum {IDLE,SETUP,ACCESS}, id_width() function, default param constants.
//  - Sub-module apb_rr_arbiter (NUM_REQ): req vector + last-grant pointer -> one-hot grant, index.
//  - Top: FSM, bus output regs, timeout counter, response regs.
// TESTING
//  1 req0 write addr 0x10 data 0xDEADBEEF, pready=1 -> psel@1, penable@2, rsp_valid@3 id0 err0.
//  2 req1 read 0x24, 3 wait states, prdata 0xA5A50001 -> penable high 4 cycles, rsp_rdata match.
//  3 req0..3 valid continuously, pready=1 -> accepts 0,1,2,3,0; psel never drops between.
//  4 pready stuck 0, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles psel=0, rsp_err=1, rdata=0.
//  5 read with pslverr=1 on pready -> rsp_err=1, rsp_rdata=prdata, next transfer unaffected.
//  6 rst_n low mid-ACCESS -> psel/penable 0 same cycle, no rsp_valid; after release req0 first.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the APB3 master controller and its arbiter.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_AW             = 8;
  localparam int DEF_DW             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Index width for n requesters; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: picks the first pending request after the last granted index, wrapping.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int cand;

  // The last-granted requester is visited last, so it only wins when it is the sole requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = ID_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master: round-robin arbitration of local requesters, one SETUP/ACCESS transfer at a time,
// with a pready timeout guarding against a hung slave. All outputs are registered.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  parameter  int AW             = DEF_AW,
  parameter  int DW             = DEF_DW,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ID_W           = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_t          state, state_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [AW-1:0]       paddr_d;
  logic [DW-1:0]       pwdata_d;
  logic [NUM_REQ-1:0]  accept_d;
  logic                rsp_valid_d, rsp_err_d;
  logic [ID_W-1:0]     rsp_id_d;
  logic [DW-1:0]       rsp_rdata_d;
  logic                load;
  logic                timeout_hit;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .last      (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // This ACCESS cycle is the TIMEOUT_CYCLES-th one without pready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(cnt) + 1) >= TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    cnt_d       = cnt;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    accept_d    = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    load        = 1'b0;

    case (state)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        load      = grant_any;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = rr_ptr;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite ? '0 : prdata;
          penable_d   = 1'b0;
          if (grant_any) begin
            load = 1'b1;
          end else begin
            psel_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          // A timed-out slave never gets a back-to-back transfer; the bus always idles first.
          rsp_valid_d = 1'b1;
          rsp_id_d    = rr_ptr;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // Latching a new winner always lands in SETUP, whether coming from IDLE or straight out of ACCESS.
    if (load) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = req_addr[int'(grant_idx)*AW +: AW];
      pwdata_d  = req_wdata[int'(grant_idx)*DW +: DW];
      pwrite_d  = req_write[grant_idx];
      accept_d  = grant;
      rr_ptr_d  = grant_idx;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req_accept <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      cnt        <= cnt_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      req_accept <= accept_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
    end
  end

endmodule
